uart_tx_fifo_drain: RTL
=======================

Name: uart_tx_fifo_drain

Overview:
- UART transmitter that sits directly downstream of the 8-entry byte FIFO.
- Pops one byte whenever the FIFO is non-empty and transmitting is enabled, then serialises it as 8N1 (start, 8 data bits LSB first, stop) on a single tx line.
- Bit timing comes from an internal baud-period counter, so no external tick is needed.
- Consumes the FIFO's show-ahead read data: rdata is valid whenever empty=0, and rd advances the read pointer at the next edge.

Parameters:
- BAUD_DIV, 10416, clk cycles per UART bit (100 MHz / 9600). Must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk
- tx_en  input  1  1 = allowed to start new frames; does not abort a frame in flight
- fifo_empty  input  1  FIFO empty flag
- fifo_rdata  input  8  FIFO head byte; valid when fifo_empty=0
- fifo_rd  output  1  pop strobe to the FIFO rd input; one cycle per byte
- tx  output  1  serial line; idle high
- tx_busy  output  1  1 while a frame is in progress (state != IDLE)
- tx_done  output  1  one-cycle pulse after each completed frame

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst=0 at a rising edge):
  - state=IDLE, tx=1, tx_done=0, baud counter=0, bit index=0, shift register=0.
  - fifo_rd is held 0 for the whole time rst=0.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - fifo_rd = (state==IDLE) & tx_en & ~fifo_empty & rst. This is combinational (Mealy) and high for at most one cycle.
  - On the edge where fifo_rd=1: latch fifo_rdata into the shift register, clear the baud counter, go to START, and register tx<=0.
  - Otherwise stay in IDLE with tx=1.
- START: tx=0 for exactly BAUD_DIV cycles. When the baud counter reaches BAUD_DIV-1, wrap the counter to 0, go to DATA, set bit index=0, and register tx<=shift[0].
- DATA:
  - Each bit is held for BAUD_DIV cycles.
  - At the end of each bit period, shift right and increment the bit index.
  - After bit 7's period, go to STOP with tx<=1.
  - The bit index is 3 bits; the exit condition is index==7 at counter==BAUD_DIV-1.
- STOP: tx=1 for BAUD_DIV cycles. At the end of the period go to IDLE and register tx_done<=1.
- tx_done is high for exactly the first IDLE cycle after STOP, then returns to 0.
- tx is a registered output: no glitches, and it changes only on bit boundaries.
- Frame length is 10*BAUD_DIV cycles.
  - tx falls in the cycle immediately after the fifo_rd cycle.
  - Back-to-back bytes have exactly one idle cycle (tx=1) between the stop bit and the next start bit.
  - Consecutive fifo_rd pulses are therefore 10*BAUD_DIV+1 cycles apart.
- tx_busy = (state != IDLE). It rises the cycle after fifo_rd and falls in the same cycle tx_done rises.
- fifo_empty and tx_en are ignored outside IDLE:
  - A mid-frame write into the FIFO is not consumed until the next IDLE cycle.
  - Deasserting tx_en mid-frame lets the current frame finish, then no further pops occur.
- The baud counter width is $clog2(BAUD_DIV). The counter wraps to 0 at BAUD_DIV-1 and never overflows.
- Reset mid-frame: on the next edge, tx=1, state=IDLE, busy=0 and no tx_done pulse. The popped byte is discarded and not re-read.
- After reset is released with the FIFO non-empty and tx_en=1, fifo_rd asserts in the first cycle with rst=1.

Test Plan (BAUD_DIV=4, so the frame is 40 cycles):
1. Hold rst=0 for 3 cycles with fifo_empty=0 and tx_en=1 -> tx=1, fifo_rd=0, tx_busy=0, tx_done=0 throughout. In the first cycle with rst=1, fifo_rd=1.
2. Single byte 0xA5 (fifo_empty drops, then rises after the pop) -> fifo_rd high for 1 cycle. tx shows 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. tx_busy high for 40 cycles. tx_done high for 1 cycle, then tx stays 1 and no second fifo_rd.
3. FIFO pre-loaded with 0x00, 0xFF, 0x3C -> three fifo_rd pulses spaced 41 cycles apart. Frames decode LSB-first to 0x00, 0xFF, 0x3C. A one-cycle tx=1 gap separates each stop bit from the next start bit. Three tx_done pulses.
4. tx_en=0 with fifo_empty=0 for 20 cycles -> no fifo_rd, tx=1. Raise tx_en -> fifo_rd the same cycle. Drop tx_en 5 cycles into the frame -> the frame completes all 40 cycles and no further fifo_rd occurs.
5. Pulse rst=0 for 1 cycle during data bit 3 -> on the next cycle tx=1, tx_busy=0, and no tx_done pulse. After release with the FIFO non-empty, fifo_rd asserts and a fresh full 40-cycle frame follows.
6. fifo_empty held 1 for 100 cycles with tx_en=1 -> fifo_rd never asserts, tx=1, tx_busy=0.

Source files
------------

// File: rtl/uart_tx_fifo_drain_if.sv
// Read-side handshake between the byte FIFO (slave) and the UART drainer (master).
// fifo_rdata is show-ahead: valid whenever fifo_empty is low.
interface uart_tx_fifo_drain_if;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       fifo_rd;

  modport master (input fifo_empty, input fifo_rdata, output fifo_rd);
  modport slave  (output fifo_empty, output fifo_rdata, input fifo_rd);
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// 8N1 UART transmitter that pops bytes straight from a show-ahead FIFO.
// Bit timing comes from an internal BAUD_DIV-cycle counter.
module uart_tx_fifo_drain #(
  parameter int unsigned BAUD_DIV = 10416
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_en,
  uart_tx_fifo_drain_if.master   fifo,
  output logic                   tx,
  output logic                   tx_busy,
  output logic                   tx_done
);

  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt, tx_done_nxt;
  logic          pop;
  logic          bit_end;

  assign bit_end      = (baud_cnt == BAUD_LAST);
  // Reset gates the pop combinationally so nothing is consumed while rst is low.
  assign fifo.fifo_rd = pop & rst;
  assign tx_busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
      tx_done  <= tx_done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift;
    tx_nxt       = tx;
    tx_done_nxt  = 1'b0;
    pop          = 1'b0;

    unique case (state)
      IDLE: begin
        tx_nxt       = 1'b1;
        baud_cnt_nxt = '0;
        if (tx_en && !fifo.fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = fifo.fifo_rdata;
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
          state_nxt    = DATA;
          tx_nxt       = shift[0];
        end else begin
          baud_cnt_nxt = CW'(baud_cnt + 1'b1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          shift_nxt    = shift >> 1;
          bit_idx_nxt  = 3'(bit_idx + 3'd1);
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            tx_nxt = shift[1];
          end
        end else begin
          baud_cnt_nxt = CW'(baud_cnt + 1'b1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          state_nxt    = IDLE;
          tx_done_nxt  = 1'b1;
        end else begin
          baud_cnt_nxt = CW'(baud_cnt + 1'b1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
